// File: rtl/if_id_skid_reg_pkg.sv
// Shared pipeline definitions for the IF/ID skid register and later stages.
//
// Contents:
//   - MIPS instruction field bit positions (HI/LO pairs), used by every
//     stage that slices a 32-bit instruction word.
//   - NOP_INSN_DEFAULT: encoding presented on the IF/ID output when no
//     valid instruction is held.
//   - Occupancy state encoding of the skid register. The encoding is
//     {skid_valid, main_valid}, so each state bit is also a valid flag.
package if_id_skid_reg_pkg;

    localparam int OP_HI   = 31;
    localparam int OP_LO   = 26;
    localparam int RS_HI   = 25;
    localparam int RS_LO   = 21;
    localparam int RT_HI   = 20;
    localparam int RT_LO   = 16;
    localparam int RD_HI   = 15;
    localparam int RD_LO   = 11;
    localparam int FUNC_HI = 5;
    localparam int FUNC_LO = 0;
    localparam int IMM_HI  = 15;
    localparam int IMM_LO  = 0;
    localparam int ADR_HI  = 25;
    localparam int ADR_LO  = 0;

    localparam logic [31:0] NOP_INSN_DEFAULT = 32'h0000_0000;

    // Bit 1 = skid entry valid, bit 0 = main entry valid.
    // 2'b10 (skid valid without main) is illegal.
    typedef logic [1:0] skid_state_t;

    localparam skid_state_t ST_EMPTY = 2'b00;
    localparam skid_state_t ST_ONE   = 2'b01;
    localparam skid_state_t ST_FULL  = 2'b11;

endpackage

// File: rtl/if_id_skid_reg_fields.sv
// mips_insn_fields: pure combinational slicing of a 32-bit MIPS instruction
// into its standard fields. Shared so ID/EX can reuse the same slicing.
//
// Ports:
//   insn  - 32-bit instruction word
//   op    - opcode         [31:26]
//   rs    - source reg     [25:21]
//   rt    - target reg     [20:16]
//   rd    - dest reg       [15:11]
//   func  - R-type funct   [5:0]
//   imm   - I-type imm     [15:0]
//   adr   - J-type target  [25:0]
module mips_insn_fields
    import if_id_skid_reg_pkg::*;
(
    input  logic [31:0] insn,
    output logic [5:0]  op,
    output logic [4:0]  rs,
    output logic [4:0]  rt,
    output logic [4:0]  rd,
    output logic [5:0]  func,
    output logic [15:0] imm,
    output logic [25:0] adr
);

    assign op   = insn[OP_HI:OP_LO];
    assign rs   = insn[RS_HI:RS_LO];
    assign rt   = insn[RT_HI:RT_LO];
    assign rd   = insn[RD_HI:RD_LO];
    assign func = insn[FUNC_HI:FUNC_LO];
    assign imm  = insn[IMM_HI:IMM_LO];
    assign adr  = insn[ADR_HI:ADR_LO];

endmodule

// File: rtl/if_id_skid_reg.sv
// if_id_skid_reg: IF/ID pipeline register with valid/ready handshakes on
// both sides and a 2-entry skid buffer. in_ready comes straight from a flop
// (the skid-valid bit), so fetch never sees a combinational path from
// decode's out_ready. Flush turns everything held into bubbles; NOP_INSN is
// shown whenever no valid entry is at the head.
//
// Ports:
//   clk          - rising-edge clock
//   reset        - asynchronous, active-low reset
//   flush        - synchronous; drops held entries and same-cycle input
//   in_valid     - fetch offers in_insn / in_pc_plus4
//   in_ready     - stage can accept this cycle (registered)
//   in_insn      - fetched instruction
//   in_pc_plus4  - PC+4 of the fetched instruction
//   out_valid    - head entry valid for decode
//   out_ready    - decode consumes the head this cycle
//   out_insn     - head instruction, or NOP_INSN when out_valid=0
//   out_pc_plus4 - head PC+4 (0 after reset/flush until the next load)
//   op/rs/rt/rd/func/imm/adr - MIPS field slices of out_insn
module if_id_skid_reg
    import if_id_skid_reg_pkg::*;
#(
    parameter int                 INSN_W   = 32,
    parameter int                 PC_W     = 32,
    parameter logic [INSN_W-1:0]  NOP_INSN = INSN_W'(NOP_INSN_DEFAULT)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [INSN_W-1:0] in_insn,
    input  logic [PC_W-1:0]   in_pc_plus4,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [INSN_W-1:0] out_insn,
    output logic [PC_W-1:0]   out_pc_plus4,
    output logic [5:0]        op,
    output logic [4:0]        rs,
    output logic [4:0]        rt,
    output logic [4:0]        rd,
    output logic [5:0]        func,
    output logic [15:0]       imm,
    output logic [25:0]       adr
);

    skid_state_t       state_q, state_d;
    logic [INSN_W-1:0] m_insn_q, m_insn_d;
    logic [PC_W-1:0]   m_pc_q, m_pc_d;
    logic [INSN_W-1:0] s_insn_q, s_insn_d;
    logic [PC_W-1:0]   s_pc_q, s_pc_d;

    logic m_v;
    logic s_v;
    logic acc;
    logic pop;
    logic [31:0] field_src;

    assign m_v = state_q[0];
    assign s_v = state_q[1];
    assign acc = in_valid & in_ready;
    assign pop = out_valid & out_ready;

    // State and data registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= ST_EMPTY;
            m_insn_q <= '0;
            m_pc_q   <= '0;
            s_insn_q <= '0;
            s_pc_q   <= '0;
        end else begin
            state_q  <= state_d;
            m_insn_q <= m_insn_d;
            m_pc_q   <= m_pc_d;
            s_insn_q <= s_insn_d;
            s_pc_q   <= s_pc_d;
        end
    end

    // Next occupancy state. Flush wins over any handshake.
    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = ST_EMPTY;
        end else begin
            unique case (state_q)
                ST_EMPTY: if (acc) state_d = ST_ONE;
                ST_ONE: begin
                    if (acc && !pop)      state_d = ST_FULL;
                    else if (!acc && pop) state_d = ST_EMPTY;
                end
                ST_FULL:  if (pop) state_d = ST_ONE;
                default:  state_d = ST_EMPTY;
            endcase
        end
    end

    // Data path. The main entry is always the head; the skid entry only
    // catches the input that arrived while decode was stalled. When the
    // buffer empties the main data is left in place and masked by m_v,
    // which keeps out_pc_plus4 showing the last head as the interface expects.
    always_comb begin
        m_insn_d = m_insn_q;
        m_pc_d   = m_pc_q;
        s_insn_d = s_insn_q;
        s_pc_d   = s_pc_q;
        if (flush) begin
            m_pc_d = '0;
            s_pc_d = '0;
        end else begin
            unique case (state_q)
                ST_EMPTY: begin
                    if (acc) begin
                        m_insn_d = in_insn;
                        m_pc_d   = in_pc_plus4;
                    end
                end
                ST_ONE: begin
                    if (acc && pop) begin
                        m_insn_d = in_insn;
                        m_pc_d   = in_pc_plus4;
                    end else if (acc) begin
                        s_insn_d = in_insn;
                        s_pc_d   = in_pc_plus4;
                    end
                end
                ST_FULL: begin
                    if (pop) begin
                        m_insn_d = s_insn_q;
                        m_pc_d   = s_pc_q;
                    end
                end
                default: begin
                    m_insn_d = m_insn_q;
                end
            endcase
        end
    end

    // Outputs are decoded from the flops only.
    always_comb begin
        in_ready     = ~s_v;
        out_valid    = m_v;
        out_insn     = m_v ? m_insn_q : NOP_INSN;
        out_pc_plus4 = m_pc_q;
    end

    assign field_src = 32'(out_insn);

    mips_insn_fields u_fields (
        .insn (field_src),
        .op   (op),
        .rs   (rs),
        .rt   (rt),
        .rd   (rd),
        .func (func),
        .imm  (imm),
        .adr  (adr)
    );

    // Protocol checks: illegal state never reached, and the head is held
    // steady while decode stalls.
    a_no_illegal_state: assert property (
        @(posedge clk) disable iff (!reset) state_q != 2'b10
    );

    a_head_stable: assert property (
        @(posedge clk) disable iff (!reset)
        (out_valid && !out_ready && !flush) |=> (out_valid && $stable(out_insn))
    );

endmodule

// File: tb/tb_if_id_skid_reg.sv
// Self-checking bench for if_id_skid_reg. A queue-based reference model
// (at most two entries, FIFO order) predicts every output each cycle;
// directed sequences add literal expectations for key points.
module tb_if_id_skid_reg;

   typedef struct packed {
      logic [31:0] insn;
      logic [31:0] pc;
   } ent_t;

   logic        clk;
   logic        reset;
   logic        flush;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_insn;
   logic [31:0] in_pc_plus4;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_insn;
   logic [31:0] out_pc_plus4;
   logic [5:0]  op;
   logic [4:0]  rs;
   logic [4:0]  rt;
   logic [4:0]  rd;
   logic [5:0]  func;
   logic [15:0] imm;
   logic [25:0] adr;

   logic        n_in_valid;
   logic        n_in_ready;
   logic [31:0] n_in_insn;
   logic [31:0] n_in_pc_plus4;
   logic        n_out_valid;
   logic        n_out_ready;
   logic [31:0] n_out_insn;
   logic [31:0] n_out_pc_plus4;
   logic [5:0]  n_op;
   logic [4:0]  n_rs;
   logic [4:0]  n_rt;
   logic [4:0]  n_rd;
   logic [5:0]  n_func;
   logic [15:0] n_imm;
   logic [25:0] n_adr;

   int checks = 0;
   int errors = 0;

   ent_t        mq[$];
   logic [31:0] m_last_pc = '0;

   if_id_skid_reg dut (
      .clk          (clk),
      .reset        (reset),
      .flush        (flush),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .in_insn      (in_insn),
      .in_pc_plus4  (in_pc_plus4),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .out_insn     (out_insn),
      .out_pc_plus4 (out_pc_plus4),
      .op           (op),
      .rs           (rs),
      .rt           (rt),
      .rd           (rd),
      .func         (func),
      .imm          (imm),
      .adr          (adr)
   );

   if_id_skid_reg #(.NOP_INSN(32'h0000_0020)) dut_nop (
      .clk          (clk),
      .reset        (reset),
      .flush        (flush),
      .in_valid     (n_in_valid),
      .in_ready     (n_in_ready),
      .in_insn      (n_in_insn),
      .in_pc_plus4  (n_in_pc_plus4),
      .out_valid    (n_out_valid),
      .out_ready    (n_out_ready),
      .out_insn     (n_out_insn),
      .out_pc_plus4 (n_out_pc_plus4),
      .op           (n_op),
      .rs           (n_rs),
      .rt           (n_rt),
      .rd           (n_rd),
      .func         (n_func),
      .imm          (n_imm),
      .adr          (n_adr)
   );

   // Free-running clock, rising edges at 5, 15, 25, ...
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // One comparison: bumps the counters and reports a mismatch.
   task automatic checkOutput(input string name, input logic [63:0] actual,
                              input logic [63:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
      end
   endtask

   // Drive one cycle of inputs at a falling edge and return at the next
   // falling edge, when the resulting outputs are settled.
   task automatic applyStimulus(input logic v, input logic [31:0] insn,
                                input logic [31:0] pc, input logic ordy,
                                input logic fl);
      in_valid    = v;
      in_insn     = insn;
      in_pc_plus4 = pc;
      out_ready   = ordy;
      flush       = fl;
      @(negedge clk);
   endtask

   // Reference model: a FIFO of at most two entries. Ready whenever fewer
   // than two are held; the head is shown when non-empty. The reported PC
   // tracks the most recent head and is cleared by reset or flush.
   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         mq.delete();
         m_last_pc = '0;
      end else begin
         bit   acc_m;
         bit   pop_m;
         ent_t e;
         acc_m = in_valid && (mq.size() < 2);
         pop_m = (mq.size() > 0) && out_ready;
         if (flush) begin
            mq.delete();
            m_last_pc = '0;
         end else begin
            if (pop_m) void'(mq.pop_front());
            if (acc_m) begin
               e.insn = in_insn;
               e.pc   = in_pc_plus4;
               mq.push_back(e);
            end
         end
         if (mq.size() > 0) m_last_pc = mq[0].pc;
      end
   end

   // Every falling edge: all outputs of the default instance against the model.
   always @(negedge clk) begin
      logic [31:0] ei;
      ei = (mq.size() > 0) ? mq[0].insn : 32'h0;
      checkOutput("out_valid", {63'b0, out_valid}, {63'b0, mq.size() > 0});
      checkOutput("in_ready", {63'b0, in_ready}, {63'b0, mq.size() < 2});
      checkOutput("out_insn", {32'b0, out_insn}, {32'b0, ei});
      checkOutput("out_pc_plus4", {32'b0, out_pc_plus4}, {32'b0, m_last_pc});
      checkOutput("op", {58'b0, op}, {58'b0, ei[31:26]});
      checkOutput("rs", {59'b0, rs}, {59'b0, ei[25:21]});
      checkOutput("rt", {59'b0, rt}, {59'b0, ei[20:16]});
      checkOutput("rd", {59'b0, rd}, {59'b0, ei[15:11]});
      checkOutput("func", {58'b0, func}, {58'b0, ei[5:0]});
      checkOutput("imm", {48'b0, imm}, {48'b0, ei[15:0]});
      checkOutput("adr", {38'b0, adr}, {38'b0, ei[25:0]});
   end

   // Directed sequence with literal expectations.
   initial begin
      reset         = 1'b1;
      flush         = 1'b0;
      in_valid      = 1'b0;
      in_insn       = '0;
      in_pc_plus4   = '0;
      out_ready     = 1'b0;
      n_in_valid    = 1'b0;
      n_in_insn     = '0;
      n_in_pc_plus4 = '0;
      n_out_ready   = 1'b0;

      // Reset held with fetch offering an instruction.
      #1 reset = 1'b0;
      in_valid    = 1'b1;
      in_insn     = 32'hDEAD_BEEF;
      in_pc_plus4 = 32'h0000_0044;
      @(negedge clk);
      @(negedge clk);
      checkOutput("rst_out_valid", {63'b0, out_valid}, 64'h0);
      checkOutput("rst_in_ready", {63'b0, in_ready}, 64'h1);
      checkOutput("rst_out_insn", {32'b0, out_insn}, 64'h0);
      checkOutput("rst_out_pc", {32'b0, out_pc_plus4}, 64'h0);

      // Release: the very next edge accepts.
      reset = 1'b1;
      applyStimulus(1'b1, 32'h1234_5678, 32'h0000_0100, 1'b0, 1'b0);
      checkOutput("first_accept", {32'b0, out_insn}, 64'h1234_5678);
      applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

      // Streaming at one instruction per cycle.
      applyStimulus(1'b1, 32'h2010_0005, 32'd4, 1'b1, 1'b0);
      checkOutput("stream_a", {32'b0, out_insn}, 64'h2010_0005);
      checkOutput("stream_a_op", {58'b0, op}, 64'h08);
      checkOutput("stream_a_rs", {59'b0, rs}, 64'h0);
      checkOutput("stream_a_rt", {59'b0, rt}, 64'h10);
      checkOutput("stream_a_imm", {48'b0, imm}, 64'h5);
      applyStimulus(1'b1, 32'h0109_5020, 32'd8, 1'b1, 1'b0);
      checkOutput("stream_b", {32'b0, out_insn}, 64'h0109_5020);
      checkOutput("stream_b_pc", {32'b0, out_pc_plus4}, 64'd8);
      applyStimulus(1'b1, 32'hAC0A_0000, 32'd12, 1'b1, 1'b0);
      checkOutput("stream_c", {32'b0, out_insn}, 64'hAC0A_0000);
      checkOutput("stream_ready", {63'b0, in_ready}, 64'h1);
      applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
      checkOutput("stream_drained", {63'b0, out_valid}, 64'h0);

      // Back-pressure: A and B fill the buffer, C is held off.
      applyStimulus(1'b1, 32'hA000_0001, 32'd16, 1'b0, 1'b0);
      applyStimulus(1'b1, 32'hB000_0002, 32'd20, 1'b0, 1'b0);
      checkOutput("bp_full_ready", {63'b0, in_ready}, 64'h0);
      checkOutput("bp_head_a", {32'b0, out_insn}, 64'hA000_0001);
      for (int i = 0; i < 3; i++) begin
         applyStimulus(1'b1, 32'hC000_0003, 32'd24, 1'b0, 1'b0);
      end
      checkOutput("bp_still_a", {32'b0, out_insn}, 64'hA000_0001);
      applyStimulus(1'b1, 32'hC000_0003, 32'd24, 1'b1, 1'b0);
      checkOutput("bp_head_b", {32'b0, out_insn}, 64'hB000_0002);
      applyStimulus(1'b1, 32'hC000_0003, 32'd24, 1'b1, 1'b0);
      checkOutput("bp_head_c", {32'b0, out_insn}, 64'hC000_0003);
      applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
      checkOutput("bp_drained", {63'b0, out_valid}, 64'h0);

      // Flush while full, with a same-cycle input that must be dropped.
      applyStimulus(1'b1, 32'hD000_0004, 32'd28, 1'b0, 1'b0);
      applyStimulus(1'b1, 32'hE000_0005, 32'd32, 1'b0, 1'b0);
      applyStimulus(1'b1, 32'hF000_0006, 32'd36, 1'b0, 1'b1);
      checkOutput("fl_out_valid", {63'b0, out_valid}, 64'h0);
      checkOutput("fl_out_insn", {32'b0, out_insn}, 64'h0);
      checkOutput("fl_out_pc", {32'b0, out_pc_plus4}, 64'h0);
      checkOutput("fl_in_ready", {63'b0, in_ready}, 64'h1);
      applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
      checkOutput("fl_dropped", {63'b0, out_valid}, 64'h0);

      // Async reset in the middle of a full buffer.
      applyStimulus(1'b1, 32'h1111_0007, 32'd40, 1'b0, 1'b0);
      applyStimulus(1'b1, 32'h2222_0008, 32'd44, 1'b0, 1'b0);
      in_valid = 1'b0;
      #2 reset = 1'b0;
      #1;
      checkOutput("ar_out_valid", {63'b0, out_valid}, 64'h0);
      checkOutput("ar_in_ready", {63'b0, in_ready}, 64'h1);
      checkOutput("ar_out_insn", {32'b0, out_insn}, 64'h0);
      checkOutput("ar_out_pc", {32'b0, out_pc_plus4}, 64'h0);
      @(negedge clk);
      reset = 1'b1;

      // NOP override instance: idle shows 0x20, then one load.
      applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
      checkOutput("nop_insn", {32'b0, n_out_insn}, 64'h20);
      checkOutput("nop_func", {58'b0, n_func}, 64'h20);
      checkOutput("nop_valid", {63'b0, n_out_valid}, 64'h0);
      n_in_valid    = 1'b1;
      n_in_insn     = 32'h8C22_0004;
      n_in_pc_plus4 = 32'd48;
      @(negedge clk);
      n_in_valid = 1'b0;
      checkOutput("nop_load_insn", {32'b0, n_out_insn}, 64'h8C22_0004);
      checkOutput("nop_load_rt", {59'b0, n_rt}, 64'h2);
      checkOutput("nop_load_valid", {63'b0, n_out_valid}, 64'h1);
      checkOutput("nop_load_pc", {32'b0, n_out_pc_plus4}, 64'd48);

      @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/if_id_skid_reg.md
Name: if_id_skid_reg

Overview:
- Parametrised successor to the single-register IF/ID latch. Sits between fetch and decode.
- Replaces the stall/flush enable pair with a valid/ready handshake on both sides, backed by a 2-entry skid buffer, so fetch never needs a combinational ready path from decode.
- Flush turns held entries into bubbles. A configurable NOP encoding is presented whenever no valid entry is present.
- MIPS field slicing of the head instruction is retained.

Parameters:
INSN_W, 32, instruction width in bits; field outputs assume 32.
PC_W, 32, width of the carried PC+4 value.
NOP_INSN, 32'h0000_0000, encoding driven on out_insn when out_valid=0.

Ports:
clk  in  1  rising-edge clock.
reset  in  1  asynchronous, active-low reset (asserted when 0).
flush  in  1  sync; discards all held entries and any same-cycle input.
in_valid  in  1  fetch presents in_insn/in_pc_plus4.
in_ready  out  1  registered; stage can accept an input this cycle.
in_insn  in  INSN_W  fetched instruction.
in_pc_plus4  in  PC_W  PC+4 of fetched instruction.
out_valid  out  1  head entry valid for decode.
out_ready  in  1  decode consumes the head this cycle.
out_insn  out  INSN_W  head instruction, or NOP_INSN when out_valid=0.
out_pc_plus4  out  PC_W  head PC+4; 0 after reset or flush until the next load.
op  out  6  out_insn[31:26].
rs  out  5  out_insn[25:21].
rt  out  5  out_insn[20:16].
rd  out  5  out_insn[15:11].
func  out  6  out_insn[5:0].
imm  out  16  out_insn[15:0].
adr  out  26  out_insn[25:0].

Behaviour:
- Storage: main entry (m_v, m_insn, m_pc) and skid entry (s_v, s_insn, s_pc).
- State encoding = {s_v, m_v}:
  - EMPTY = 00
  - ONE = 01
  - FULL = 11
  - 10 is illegal and must never be reached.
- Reset (reset=0, async):
  - m_v = s_v = 0; all data registers = 0.
  - in_ready = 1, out_valid = 0, out_insn = NOP_INSN, out_pc_plus4 = 0.
- Combinational relationships:
  - in_ready = ~s_v, driven straight from a flop.
  - out_valid = m_v.
  - out_insn = m_v ? m_insn : NOP_INSN.
  - Field ports are pure slices of out_insn.
- Handshake events: acc = in_valid & in_ready; pop = out_valid & out_ready.
- Transitions when flush=0:
  - EMPTY: acc -> load main, go to ONE.
  - ONE, acc & ~pop: load skid, go to FULL (in_ready drops next cycle).
  - ONE, acc & pop: main <= input, stay in ONE (full throughput, 1 insn/cycle).
  - ONE, ~acc & pop: go to EMPTY; m_insn/m_pc keep their value but are masked by m_v.
  - FULL, pop: main <= skid, s_v <= 0, go to ONE. acc is impossible because in_ready=0.
  - FULL, ~pop: hold everything.
- Latency: an accepted input appears on out_* the cycle after acceptance. Ordering is strictly FIFO.
- Flush (highest synchronous priority):
  - Next state is EMPTY; m_pc and s_pc are cleared to 0; in_ready = 1 next cycle.
  - A same-cycle acc is dropped.
  - A same-cycle pop is still considered consumed by decode, with no extra effect.
- in_valid while in_ready=0 is ignored; the sender must hold its data.
- Reset asserted mid-operation clears immediately, independent of clk.
- Protocol assertions:
  - State 10 never occurs.
  - out_insn is stable while out_valid & ~out_ready.

Decomposition:
- Shared pipeline package holds:
  - MIPS field bit-position constants (OP_HI/LO, RS_HI/LO, RT_, RD_, FUNC_, IMM_, ADR_).
  - NOP_INSN default.
  - The EMPTY/ONE/FULL state localparams.
- No sub-module is needed. The field-slicing block may be a shared combinational module mips_insn_fields, reused later by ID/EX.

Test Plan:
- Reset: hold reset=0 with in_valid=1 -> out_valid=0, out_insn=0, in_ready=1, out_pc_plus4=0. Release reset -> first accept occurs on the next edge.
- Streaming: out_ready=1; push 0x2010_0005/pc 4, 0x0109_5020/pc 8, 0xAC0A_0000/pc 12 on consecutive cycles -> they appear one cycle later on consecutive cycles. in_ready stays 1 throughout. op=0x08, rs=0, rt=0x10, imm=5 for the first.
- Back-pressure: out_ready=0, push A then B -> state FULL and in_ready=0. Hold C on in_valid for 3 cycles -> not taken. Raise out_ready -> A, B, C delivered in order with no loss or duplication.
- Flush in FULL, with in_valid=1 in the same cycle -> next cycle out_valid=0, out_insn=0x0, out_pc_plus4=0, in_ready=1. The dropped input never appears.
- NOP override: build with NOP_INSN=32'h0000_0020; leave the stage idle -> out_insn=0x20 and func=0x20. Then push 0x8C22_0004 -> out_insn shows it, rt=2.
- Async reset mid-FULL: assert reset between clock edges -> outputs clear immediately without waiting for clk.
